// File: rtl/adc_spi_responder.sv
// SPI-style ADC responder: returns a 12-bit channel sample MSB-first while
// clocking in a 6-bit config word that selects the channel for the next frame.
module adc_spi_responder #(
   parameter int unsigned DEFAULT_CH   = 0,
   parameter int unsigned MIN_SCLK_DIV = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [95:0] ch_data,
   input  logic        ADC_SCLK,
   input  logic        ADC_CS_N,
   input  logic        ADC_DIN,
   output logic        ADC_DOUT,
   output logic [2:0]  channel_sel,
   output logic [5:0]  cfg_word,
   output logic        busy,
   output logic        frame_done,
   output logic        frame_err
);

   // Each synced SCLK phase must span at least two clocks for edge detection.
   if (MIN_SCLK_DIV < 4) begin : g_div_check
      $error("adc_spi_responder: MIN_SCLK_DIV must be at least 4");
   end

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } state_t;

   state_t      state;
   logic [2:0]  sclk_q;
   logic [2:0]  cs_q;
   logic [2:0]  din_q;
   logic [11:0] shift_out;
   logic [5:0]  cfg_shift;
   logic [3:0]  bit_cnt;
   logic        cs_pend;
   logic [11:0] sample;

   logic sclk_rise;
   logic sclk_fall;
   logic cs_rise;
   logic cs_fall;
   logic din_s;

   // [0],[1] synchronize; [2] is the edge-detect register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sclk_q <= '0;
         cs_q   <= '0;
         din_q  <= '0;
      end else begin
         sclk_q <= {sclk_q[1:0], ADC_SCLK};
         cs_q   <= {cs_q[1:0], ADC_CS_N};
         din_q  <= {din_q[1:0], ADC_DIN};
      end
   end

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign cs_rise   = cs_q[1] & ~cs_q[2];
   assign cs_fall   = ~cs_q[1] & cs_q[2];
   assign din_s     = din_q[2];

   always_comb begin
      sample = ch_data[11:0];
      case (channel_sel)
         3'd0: sample = ch_data[11:0];
         3'd1: sample = ch_data[23:12];
         3'd2: sample = ch_data[35:24];
         3'd3: sample = ch_data[47:36];
         3'd4: sample = ch_data[59:48];
         3'd5: sample = ch_data[71:60];
         3'd6: sample = ch_data[83:72];
         3'd7: sample = ch_data[95:84];
         default: sample = ch_data[11:0];
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ADC_DOUT    <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
         bit_cnt     <= '0;
         shift_out   <= '0;
         cfg_shift   <= '0;
         cs_pend     <= 1'b0;
         channel_sel <= 3'(DEFAULT_CH);
         cfg_word    <= '0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               busy     <= 1'b0;
               ADC_DOUT <= 1'b0;
               if (cs_fall || cs_pend) begin
                  cs_pend   <= 1'b0;
                  shift_out <= sample;
                  cfg_shift <= '0;
                  bit_cnt   <= '0;
                  busy      <= 1'b1;
                  ADC_DOUT  <= sample[11];
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               // CS_N rising wins over any coincident SCLK edge.
               if (cs_rise) begin
                  busy     <= 1'b0;
                  ADC_DOUT <= 1'b0;
                  if (bit_cnt == 4'd12) begin
                     state <= COMMIT;
                  end else begin
                     frame_err <= 1'b1;
                     cfg_shift <= '0;
                     state     <= IDLE;
                  end
               end else if (sclk_rise) begin
                  if (bit_cnt < 4'd6) begin
                     cfg_shift <= {cfg_shift[4:0], din_s};
                  end
                  if (bit_cnt != 4'd12) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else if (sclk_fall) begin
                  if (bit_cnt < 4'd12) begin
                     ADC_DOUT  <= shift_out[10];
                     shift_out <= {shift_out[10:0], 1'b0};
                  end else begin
                     ADC_DOUT <= 1'b0;
                  end
               end
            end
            COMMIT: begin
               cfg_word   <= cfg_shift;
               frame_done <= 1'b1;
               busy       <= 1'b0;
               if (cfg_shift[5]) begin
                  channel_sel <= {cfg_shift[3], cfg_shift[2], cfg_shift[4]};
               end
               // A frame start seen here is replayed from IDLE next cycle.
               cs_pend <= cs_fall;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: SCLK = clock/16, immediate-assertion checks.
module tb_adc_spi_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [95:0] ch_data;
   logic        sclk  = 1'b0;
   logic        cs_n  = 1'b1;
   logic        din   = 1'b0;
   logic        dout;
   logic [2:0]  channel_sel;
   logic [5:0]  cfg_word;
   logic        busy;
   logic        frame_done;
   logic        frame_err;

   int vectors    = 0;
   int miscompares = 0;
   int done_cnt   = 0;
   int err_cnt    = 0;
   logic [15:0] cap;
   logic [95:0] alt_data;
   int d0;
   int e0;

   adc_spi_responder #(.DEFAULT_CH(0), .MIN_SCLK_DIV(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .ch_data     (ch_data),
      .ADC_SCLK    (sclk),
      .ADC_CS_N    (cs_n),
      .ADC_DIN     (din),
      .ADC_DOUT    (dout),
      .channel_sel (channel_sel),
      .cfg_word    (cfg_word),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_err   (frame_err)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (frame_done) done_cnt <= done_cnt + 1;
      if (frame_err)  err_cnt  <= err_cnt + 1;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic open_frame();
      cs_n = 1'b1;
      wait_clk(8);
      cs_n = 1'b0;
      wait_clk(8);
   endtask

   // DOUT is sampled at the end of each SCLK low phase; cap[15] holds the first bit.
   task automatic shift_bits(input logic [5:0] cfg, input int n, input int change_at,
                             input logic [95:0] new_data);
      cap = '0;
      for (int k = 0; k < n; k++) begin
         if (k == change_at) ch_data = new_data;
         din = (k < 6) ? cfg[5-k] : 1'b0;
         wait_clk(8);
         cap[15-k] = dout;
         sclk = 1'b1;
         wait_clk(8);
         sclk = 1'b0;
      end
      din = 1'b0;
      wait_clk(8);
   endtask

   task automatic full_frame(input string tag, input logic [5:0] cfg, input int n,
                             input int change_at, input logic [95:0] new_data,
                             input logic [15:0] exp_cap, input logic [2:0] exp_ch,
                             input logic [5:0] exp_cfg, input int exp_done, input int exp_err);
      int fd;
      int fe;
      fd = done_cnt;
      fe = err_cnt;
      open_frame();
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      shift_bits(cfg, n, change_at, new_data);
      if (n >= 12) chk({tag, "_dout_tail"}, 32'(dout), 32'd0);
      cs_n = 1'b1;
      wait_clk(12);
      chk({tag, "_cap"}, 32'(cap), 32'(exp_cap));
      chk({tag, "_done"}, 32'(done_cnt - fd), 32'(exp_done));
      chk({tag, "_err"}, 32'(err_cnt - fe), 32'(exp_err));
      chk({tag, "_ch"}, 32'(channel_sel), 32'(exp_ch));
      chk({tag, "_cfg"}, 32'(cfg_word), 32'(exp_cfg));
      chk({tag, "_idle"}, 32'({busy, dout}), 32'd0);
   endtask

   initial begin
      ch_data = {12'h0F0, 12'hDEF, 12'hABC, 12'h789, 12'h456, 12'h123, 12'h3F1, 12'hA5C};

      wait_clk(5);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pulses", 32'({frame_done, frame_err}), 32'd0);
      chk("rst_ch", 32'(channel_sel), 32'd0);
      chk("rst_cfg", 32'(cfg_word), 32'd0);
      reset = 1'b1;
      wait_clk(10);
      chk("rel_busy", 32'(busy), 32'd0);

      full_frame("f1", 6'b100010, 12, -1, ch_data, 16'hA5C0, 3'd0, 6'h22, 1, 0);
      full_frame("f2", 6'b110010, 12, -1, ch_data, 16'hA5C0, 3'd1, 6'h32, 1, 0);
      full_frame("f3", 6'b101101, 12, -1, ch_data, 16'h3F10, 3'd6, 6'h2D, 1, 0);
      full_frame("short", 6'b111111, 7, -1, ch_data, 16'hDE00, 3'd6, 6'h2D, 0, 1);
      full_frame("diff", 6'b001010, 12, -1, ch_data, 16'hDEF0, 3'd6, 6'h0A, 1, 0);
      full_frame("f6", 6'b111001, 12, -1, ch_data, 16'hDEF0, 3'd5, 6'h39, 1, 0);

      alt_data = ch_data;
      alt_data[71:60] = 12'h555;
      full_frame("long", 6'b100110, 16, 4, alt_data, 16'hABC0, 3'd2, 6'h26, 1, 0);

      d0 = done_cnt;
      e0 = err_cnt;
      open_frame();
      shift_bits(6'b110000, 5, -1, ch_data);
      reset = 1'b0;
      wait_clk(4);
      chk("abort_dout", 32'(dout), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ch", 32'(channel_sel), 32'd0);
      chk("abort_cfg", 32'(cfg_word), 32'd0);
      reset = 1'b1;
      wait_clk(20);
      chk("held_low_busy", 32'(busy), 32'd0);
      chk("abort_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

      full_frame("f8", 6'b110110, 12, -1, ch_data, 16'hA5C0, 3'd3, 6'h36, 1, 0);

      d0 = done_cnt;
      open_frame();
      shift_bits(6'b000000, 12, -1, ch_data);
      cs_n = 1'b1;
      wait_clk(1);
      cs_n = 1'b0;
      wait_clk(8);
      chk("f9_cap", 32'(cap), 32'(16'h4560));
      chk("f9_cfg", 32'(cfg_word), 32'd0);
      chk("f9_ch", 32'(channel_sel), 32'd3);
      chk("b2b_busy", 32'(busy), 32'd1);
      shift_bits(6'b101001, 12, -1, ch_data);
      cs_n = 1'b1;
      wait_clk(12);
      chk("b2b_cap", 32'(cap), 32'(16'h4560));
      chk("b2b_ch", 32'(channel_sel), 32'd4);
      chk("b2b_cfg", 32'(cfg_word), 32'h29);
      chk("b2b_done", 32'(done_cnt - d0), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 Parameter DEFAULT_CH, default 0, channel selected after reset (0-7).
REQ-002 Parameter MIN_SCLK_DIV, default 8, minimum clock cycles per ADC_SCLK period that the block supports.
REQ-003 clock  in  1  single system clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; asserted (0) forces reset state immediately.
REQ-005 ch_data  in  96  eight 12-bit channel samples, CH0 in [11:0] through CH7 in [95:84].
REQ-006 ADC_SCLK  in  1  serial clock from the initiator, asynchronous to clock.
REQ-007 ADC_CS_N  in  1  frame select/convert strobe from the initiator, asynchronous to clock.
REQ-008 ADC_DIN  in  1  serial config word from the initiator, asynchronous to clock.
REQ-009 ADC_DOUT  out  1  serial conversion result, MSB first.
REQ-010 channel_sel  out  3  channel that will be sampled by the next frame.
REQ-011 cfg_word  out  6  last committed config word {S/D,O/S,S1,S0,UNI,SLP}.
REQ-012 busy  out  1  high while a frame is in progress.
REQ-013 frame_done  out  1  one-cycle pulse on a valid frame end.
REQ-014 frame_err  out  1  one-cycle pulse on a short frame.

Function
REQ-015 ADC_SCLK, ADC_CS_N and ADC_DIN SHALL each pass through a 2-flop synchronizer plus one edge-detect register; edge-to-action latency SHALL be 3 clock cycles from the raw pin edge.
REQ-016 FSM states SHALL be IDLE, SHIFT and COMMIT.
REQ-017 IDLE: busy=0, ADC_DOUT=0; a synced ADC_CS_N falling edge SHALL load shift_out <= ch_data[channel_sel], clear bit_cnt, set busy=1, drive ADC_DOUT = sample bit 11, and enter SHIFT.
REQ-018 The sample SHALL be captured only at the CS_N falling edge; changes to ch_data during a frame SHALL be ignored.
REQ-019 SHIFT, synced SCLK rising edge: if bit_cnt<6, shift ADC_DIN into cfg_shift (first bit = S/D); bit_cnt SHALL increment and saturate at 12.
REQ-020 SHIFT, synced SCLK falling edge: if bit_cnt<12, ADC_DOUT SHALL advance to the next lower sample bit; once bit_cnt=12, ADC_DOUT SHALL be 0.
REQ-021 SCLK edges beyond the 12th SHALL be ignored, with no error.
REQ-022 SHIFT, synced CS_N rising edge: SHALL enter COMMIT if bit_cnt=12, else SHALL pulse frame_err, discard cfg_shift, leave channel_sel and cfg_word unchanged, and return to IDLE.
REQ-023 COMMIT (one cycle): cfg_word <= cfg_shift; frame_done=1; busy=0; return to IDLE.
REQ-024 COMMIT with S/D=1: channel_sel SHALL become {S1,S0,O/S} (000->0, 100->1, 001->2, 101->3, 010->4, 110->5, 011->6, 111->7).
REQ-025 COMMIT with S/D=0 (differential): channel_sel SHALL be unchanged; cfg_word SHALL still update.
REQ-026 UNI and SLP SHALL be recorded in cfg_word only; the sample SHALL be output unmodified.
REQ-027 Simultaneous synced SCLK edge and CS_N rising edge: the CS_N edge SHALL take priority and the SCLK edge SHALL be dropped.
REQ-028 A CS_N falling edge while in COMMIT SHALL start a new frame on the following IDLE cycle; the edge SHALL not be lost.
REQ-029 Correct operation SHALL be required only for SCLK period >= MIN_SCLK_DIV clocks, with each SCLK phase >= MIN_SCLK_DIV/2 clocks.

Reset
REQ-030 On reset=0: state=IDLE, ADC_DOUT=0, busy=0, frame_done=0, frame_err=0, bit_cnt=0, channel_sel=DEFAULT_CH, cfg_word=0.
REQ-031 CS_N synchronizer and edge registers SHALL reset to 0 and SCLK registers to 0, so that no edge is detected at reset release; a frame SHALL require a high-then-low CS_N after reset.
REQ-032 Reset mid-frame SHALL abort the frame with no frame_done or frame_err pulse.

Verification
REQ-033 ch_data CH0=12'hA5C, SCLK=clock/16, DIN=6'b100010, 12 clocks -> DOUT bits A5C MSB-first, frame_done pulse, channel_sel=0, cfg_word=100010.
REQ-034 Frame with DIN=6'b110010 then second frame, CH1=12'h3F1 -> first frame channel_sel=1; second frame DOUT=3F1.
REQ-035 CS_N rises after 7 SCLK -> frame_err single pulse; channel_sel and cfg_word unchanged; DOUT=0.
REQ-036 DIN=6'b001010 (differential) -> cfg_word=001010, channel_sel unchanged, frame_done pulse.
REQ-037 reset asserted at bit 5 with CS_N held low, then released -> outputs at reset values; no frame until CS_N goes high then low; next full frame correct.
REQ-038 16 SCLKs in one frame and ch_data changed mid-frame -> DOUT = sample captured at CS_N fall, then 0 for the extra clocks; frame_done with no frame_err.
